// File: rtl/risc_stream_mux_pkg.sv
// Shared constants and helpers for the RISC stream multiplexer.
package risc_stream_mux_pkg;

    // Selection modes for the stream multiplexer
    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Index of the channel after idx, wrapping N-1 back to 0
    function automatic int next_index(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/risc_stream_mux_if.sv
// Handshake bundle between producers, the stream mux and its consumer.
interface risc_stream_mux_if #(
    parameter int WIDTH = 16,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_ch;

    // Producer/consumer side of the mux
    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    // The mux itself
    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/risc_stream_mux_rr_arbiter.sv
// Rotating-priority encoder: first requester at or after ptr wins.
module risc_rr_arbiter #(
    parameter int N = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx
);
    int   cand;
    logic found;

    // Scan channels ptr, ptr+1, ... modulo N and grant the first requester
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand[SELW-1:0];
            end
        end
    end
endmodule

// File: rtl/risc_stream_mux.sv
// Registered N-input stream mux with external-select or round-robin choice.
module risc_stream_mux
    import risc_stream_mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int MODE  = MODE_SEL
) (
    input logic clk,
    input logic rst,
    risc_stream_mux_if.slave bus
);
    localparam int SELW = $clog2(N);

    logic               load_en;
    logic               xfer;
    logic [N-1:0]       ready_vec;
    logic [SELW-1:0]    grant_idx;
    logic [WIDTH-1:0]   pick_data;
    logic [WIDTH-1:0]   data_q;
    logic [SELW-1:0]    ch_q;
    logic               valid_q;

    // Reset blocks acceptance so nothing is taken in a reset cycle
    assign load_en = !rst && (!valid_q || bus.out_ready);
    assign xfer    = |(bus.in_valid & ready_vec);

    assign bus.in_ready  = ready_vec;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_ch    = ch_q;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SELW-1:0] ptr;
            logic [N-1:0]    grant;
            logic [SELW-1:0] arb_idx;

            risc_rr_arbiter #(.N(N)) u_arb (
                .req   (bus.in_valid),
                .ptr   (ptr),
                .grant (grant),
                .idx   (arb_idx)
            );

            assign ready_vec = load_en ? grant : '0;
            assign grant_idx = arb_idx;

            // Pointer moves just past the granted channel on each accepted item
            always_ff @(posedge clk) begin
                if (rst) begin
                    ptr <= '0;
                end else if (xfer) begin
                    ptr <= SELW'(next_index(int'(arb_idx), N));
                end
            end
        end else begin : g_sel
            assign grant_idx = bus.sel;

            // Only the selected channel is offered ready; out-of-range sel offers none
            always_comb begin
                ready_vec = '0;
                for (int i = 0; i < N; i++) begin
                    ready_vec[i] = load_en && (int'(bus.sel) == i);
                end
            end
        end
    endgenerate

    // Pick the granted channel's data; it only ever feeds the output register
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                pick_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-entry output register: load replaces, drain without load empties
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
        end else if (xfer) begin
            valid_q <= 1'b1;
            data_q  <= pick_data;
            ch_q    <= grant_idx;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_risc_stream_mux.sv
// Directed bench for risc_stream_mux in select and round-robin modes.
module tb_risc_stream_mux;
    import risc_stream_mux_pkg::*;

    localparam int WIDTH = 16;
    localparam int N     = 4;

    localparam logic [15:0] D0 = 16'hA000;
    localparam logic [15:0] D1 = 16'hB111;
    localparam logic [15:0] D2 = 16'hBEEF;
    localparam logic [15:0] D3 = 16'hD333;

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [1:0]  exp_ch;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[12];

    risc_stream_mux_if #(.WIDTH(WIDTH), .N(N)) if_sel ();
    risc_stream_mux_if #(.WIDTH(WIDTH), .N(N)) if_rr ();

    risc_stream_mux #(.WIDTH(WIDTH), .N(N), .MODE(MODE_SEL)) dut_sel (
        .clk (clk),
        .rst (rst),
        .bus (if_sel.slave)
    );

    risc_stream_mux #(.WIDTH(WIDTH), .N(N), .MODE(MODE_RR)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (if_rr.slave)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if_sel.sel       = v.sel;
        if_sel.in_valid  = v.valid;
        if_sel.out_ready = v.ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRegs(input string tag, input logic v, input logic [15:0] d, input logic [1:0] c,
                             input logic rr);
        if (rr) begin
            checkOutput({tag, " rr valid"}, 32'(if_rr.out_valid), 32'(v));
            checkOutput({tag, " rr data"},  32'(if_rr.out_data),  32'(d));
            checkOutput({tag, " rr ch"},    32'(if_rr.out_ch),    32'(c));
        end else begin
            checkOutput({tag, " sel valid"}, 32'(if_sel.out_valid), 32'(v));
            checkOutput({tag, " sel data"},  32'(if_sel.out_data),  32'(d));
            checkOutput({tag, " sel ch"},    32'(if_sel.out_ch),    32'(c));
        end
    endtask

    initial begin
        logic [3:0] exp_r;
        logic [15:0] dtab [4];
        checks = 0;
        errors = 0;
        dtab[0] = D0; dtab[1] = D1; dtab[2] = D2; dtab[3] = D3;

        //                 sel    valid    ordy  ready    v     data ch
        vecs[0]  = '{2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, D2, 2'd2};
        vecs[1]  = '{2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, D2, 2'd2};
        vecs[2]  = '{2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, D1, 2'd1};
        vecs[3]  = '{2'd2, 4'b0000, 1'b1, 4'b0100, 1'b0, D1, 2'd1};
        vecs[4]  = '{2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, D3, 2'd3};
        vecs[5]  = '{2'd3, 4'b1000, 1'b0, 4'b0000, 1'b1, D3, 2'd3};
        vecs[6]  = '{2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, D3, 2'd3};
        vecs[7]  = '{2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, D0, 2'd0};
        vecs[8]  = '{2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, D0, 2'd0};
        vecs[9]  = '{2'd0, 4'b0000, 1'b1, 4'b0001, 1'b0, D0, 2'd0};
        vecs[10] = '{2'd1, 4'b0000, 1'b0, 4'b0010, 1'b0, D0, 2'd0};
        vecs[11] = '{2'd2, 4'b0000, 1'b1, 4'b0100, 1'b0, D0, 2'd0};

        if_sel.in_data = {D3, D2, D1, D0};
        if_rr.in_data  = {D3, D2, D1, D0};
        if_rr.sel      = '0;

        // Reset held two cycles with every channel valid
        rst = 1'b1;
        if_sel.sel = 2'd0;
        if_sel.in_valid = 4'b1111;
        if_sel.out_ready = 1'b0;
        if_rr.in_valid = 4'b1111;
        if_rr.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checkRegs("reset", 1'b0, 16'h0, 2'd0, 1'b0);
            checkRegs("reset", 1'b0, 16'h0, 2'd0, 1'b1);
            checkOutput("reset sel ready", 32'(if_sel.in_ready), 32'h0);
            checkOutput("reset rr ready",  32'(if_rr.in_ready),  32'h0);
        end
        rst = 1'b0;
        #1;
        checkOutput("post-reset sel ready", 32'(if_sel.in_ready), 32'b0001);
        checkOutput("post-reset rr ready",  32'(if_rr.in_ready),  32'b0001);
        tick();
        checkRegs("first accept", 1'b1, D0, 2'd0, 1'b0);
        checkRegs("first accept", 1'b1, D0, 2'd0, 1'b1);
        if_sel.in_valid = 4'b0000;
        if_sel.out_ready = 1'b1;
        if_rr.in_valid = 4'b0000;
        if_rr.out_ready = 1'b1;
        tick();
        checkOutput("drain sel valid", 32'(if_sel.out_valid), 32'h0);
        checkOutput("drain rr valid",  32'(if_rr.out_valid),  32'h0);

        // Select-mode vectors, including backpressure and no-bubble reload
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d ready", i), 32'(if_sel.in_ready), 32'(vecs[i].exp_ready));
            tick();
            checkRegs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_ch, 1'b0);
        end

        // Fresh reset, then round-robin with every channel valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_rr.in_valid = 4'b1111;
        if_rr.out_ready = 1'b1;
        #1;
        checkOutput("rr start ready", 32'(if_rr.in_ready), 32'b0001);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkRegs($sformatf("rr cycle%0d", i), 1'b1, dtab[i % 4], 2'(i % 4), 1'b1);
            exp_r = 4'b0001 << ((i + 1) % 4);
            checkOutput($sformatf("rr cycle%0d ready", i), 32'(if_rr.in_ready), 32'(exp_r));
        end

        // Skipping: move ptr to 1, then only channels 3 and 0 request
        if_rr.in_valid = 4'b0001;
        tick();
        checkRegs("rr set ptr", 1'b1, D0, 2'd0, 1'b1);
        if_rr.in_valid = 4'b1001;
        #1;
        checkOutput("rr skip ready3", 32'(if_rr.in_ready), 32'b1000);
        tick();
        checkRegs("rr skip grant3", 1'b1, D3, 2'd3, 1'b1);
        checkOutput("rr skip ready0", 32'(if_rr.in_ready), 32'b0001);
        tick();
        checkRegs("rr skip grant0", 1'b1, D0, 2'd0, 1'b1);

        // Reset during a stall discards the held item and rewinds ptr
        if_rr.in_valid = 4'b0100;
        tick();
        checkRegs("stall load", 1'b1, D2, 2'd2, 1'b1);
        if_rr.in_valid = 4'b0000;
        if_rr.out_ready = 1'b0;
        tick();
        checkRegs("stall hold", 1'b1, D2, 2'd2, 1'b1);
        checkOutput("stall ready", 32'(if_rr.in_ready), 32'h0);
        rst = 1'b1;
        tick();
        checkRegs("mid reset", 1'b0, 16'h0, 2'd0, 1'b1);
        rst = 1'b0;
        if_rr.in_valid = 4'b1111;
        if_rr.out_ready = 1'b1;
        #1;
        checkOutput("after reset ptr", 32'(if_rr.in_ready), 32'b0001);
        tick();
        checkRegs("after reset item0", 1'b1, D0, 2'd0, 1'b1);
        tick();
        checkRegs("after reset item1", 1'b1, D1, 2'd1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
